// File: rtl/mdu_seq.sv
// mdu_seq: sequential multiply/divide unit that owns the HI/LO register pair.
// Radix-2 iterative datapath, one bit per cycle; WIDTH+1 cycles per op.
// Optional feature macro: MDU_ACCUM_EN (enables MADD/MSUB, op 100/101).
//
// Handshake: start is sampled only while the FSM is IDLE. An accepted
// MULT/DIV/MADD/MSUB raises busy from the next edge until the edge that
// writes HI/LO; done then pulses high for exactly one cycle. start seen
// while busy is dropped, so the issuer must hold off until busy=0.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sin,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MTHI = 3'b000;
  localparam logic [2:0] OP_MTLO = 3'b001;
  localparam logic [2:0] OP_MULT = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
`ifdef MDU_ACCUM_EN
  localparam logic [2:0] OP_MADD = 3'b100;
  localparam logic [2:0] OP_MSUB = 3'b101;
`else
  // op 100/101 are reserved in this build and fall into the ignored set.
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2:0]         op_r;
  logic               neg_a, neg_b;
  logic [WIDTH:0]     a_mag, b_mag;
  logic [WIDTH-1:0]   a_raw;
  // Shared work register: MULT = {partial high, multiplier/low product},
  // DIV = {remainder, dividend shifting into quotient}.
  logic [2*WIDTH-1:0] p;

  logic               iter_op;
  logic               in1_neg, in2_neg;
  logic [WIDTH:0]     in1_ext, in2_ext, in1_mag, in2_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic               b_zero;
`ifdef MDU_ACCUM_EN
  logic [2*WIDTH-1:0] acc_add, acc_sub;
`endif

  // Decode which op codes start an iterative operation.
  always_comb begin
    iter_op = 1'b0;
    case (op)
      OP_MULT, OP_DIV: iter_op = 1'b1;
`ifdef MDU_ACCUM_EN
      OP_MADD, OP_MSUB: iter_op = 1'b1;
`endif
      default: iter_op = 1'b0;
    endcase
  end

  // Operand magnitudes in WIDTH+1 bits so the most-negative value is exact.
  always_comb begin
    in1_neg = sin & in_1[WIDTH-1];
    in2_neg = sin & in_2[WIDTH-1];
    in1_ext = {in1_neg, in_1};
    in2_ext = {in2_neg, in_2};
    in1_mag = in1_neg ? -in1_ext : in1_ext;
    in2_mag = in2_neg ? -in2_ext : in2_ext;
  end

  // One shift-add step and one restoring-divide step, plus sign fix-up.
  always_comb begin
    mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? a_mag : '0);
    mul_next  = {mul_sum, p[WIDTH-1:1]};
    div_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    div_ge    = (div_shift >= b_mag);
    // When div_ge holds the true difference is below the divisor, so the
    // low WIDTH bits are the whole result.
    div_diff  = div_shift[WIDTH-1:0] - b_mag[WIDTH-1:0];
    div_next  = div_ge ? {div_diff, p[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
    prod_fix  = (neg_a ^ neg_b) ? -p : p;
    q_fix     = (neg_a ^ neg_b) ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    r_fix     = neg_a ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    b_zero    = (b_mag == '0);
  end

`ifdef MDU_ACCUM_EN
  // Accumulate paths, modulo 2^(2*WIDTH).
  always_comb begin
    acc_add = {hi, lo} + prod_fix;
    acc_sub = {hi, lo} - prod_fix;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state: IDLE -> CALC (WIDTH cycles) -> FIX -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && iter_op) state_nxt = S_CALC;
      S_CALC:  if (cnt == '0)        state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

  // Operand latch on accept, then one datapath step per CALC cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      op_r  <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      a_mag <= '0;
      b_mag <= '0;
      a_raw <= '0;
      p     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && iter_op) begin
            op_r  <= op;
            neg_a <= in1_neg;
            neg_b <= in2_neg;
            a_mag <= in1_mag;
            b_mag <= in2_mag;
            a_raw <= in_1;
            cnt   <= CW'(WIDTH - 1);
            p     <= (op == OP_DIV) ? {{WIDTH{1'b0}}, in1_mag[WIDTH-1:0]}
                                    : {{WIDTH{1'b0}}, in2_mag[WIDTH-1:0]};
          end
        end
        S_CALC: begin
          p   <= (op_r == OP_DIV) ? div_next : mul_next;
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // HI/LO writes (MTHI/MTLO in IDLE, results at the FIX edge) and done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE && start) begin
        case (op)
          OP_MTHI: hi <= in_1;
          OP_MTLO: lo <= in_1;
          default: ;
        endcase
      end else if (state == S_FIX) begin
        done <= 1'b1;
        case (op_r)
          OP_DIV: begin
            if (b_zero) begin
              hi <= a_raw;
              lo <= '1;
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end
`ifdef MDU_ACCUM_EN
          OP_MADD: {hi, lo} <= acc_add;
          OP_MSUB: {hi, lo} <= acc_sub;
`endif
          default: {hi, lo} <= prod_fix;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed-vector bench for mdu_seq (WIDTH=32) with an
// expected-result queue drained by a done-driven monitor.
module tb_mdu_seq;

  localparam int W = 32;
  localparam logic [2:0] OP_MTHI = 3'b000;
  localparam logic [2:0] OP_MTLO = 3'b001;
  localparam logic [2:0] OP_MULT = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_MADD = 3'b100;
  localparam logic [2:0] OP_MSUB = 3'b101;
  localparam logic [2:0] OP_NONE = 3'b111;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic           sin = 1'b0;
  logic [2:0]     op = OP_NONE;
  logic [W-1:0]   in_1 = '0;
  logic [W-1:0]   in_2 = '0;
  logic           busy, done;
  logic [W-1:0]   hi, lo;
  logic [1:0]     fsm_state;

  logic [2*W-1:0] exp_q[$];
  int             total = 0;
  int             bad = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  mdu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sin(sin), .op(op),
    .in_1(in_1), .in_2(in_2), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .fsm_state(fsm_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no result", hi, lo);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        if ({hi, lo} !== e) begin
          bad++;
          $display("FAIL result: got %h_%h expected %h_%h", hi, lo, e[2*W-1:W], e[W-1:0]);
        end
      end
    end
  end

  // Driver: issue an iterative op and record its expected {hi,lo}.
  task automatic issue(input logic [2:0] o, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2*W-1:0] exp);
    exp_q.push_back(exp);
    op = o; sin = s; in_1 = a; in_2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
    in_1 = $urandom; in_2 = $urandom;
  endtask

  // Driver: MTHI/MTLO, checked at the very next edge.
  task automatic mt(input string name, input logic [2:0] o, input logic [W-1:0] v,
                    input logic [2*W-1:0] exp);
    op = o; in_1 = v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
    check(name, {hi, lo}, exp);
    check({name, "_busy"}, busy, 0);
  endtask

  // Wait (bounded) for a done pulse; returns on the negedge of the done cycle.
  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < W + 10; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    check({name, "_done_seen"}, seen, 1);
  endtask

  // Count busy cycles after an issue, then check the single-cycle done pulse.
  task automatic measure(input string name);
    int n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    check({name, "_busy_len"}, n, W + 1);
    check({name, "_done_pulse"}, done, 1);
    @(negedge clk);
    check({name, "_done_clear"}, done, 0);
  endtask

  initial begin
    int viol;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_hilo", {hi, lo}, 64'h0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1. Signed MULT -3*5 with latency check
    issue(OP_MULT, 1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    measure("mult_neg");
    @(negedge clk);

    // 2. Divides
    issue(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_done("div_m7_2"); @(negedge clk);
    issue(OP_DIV, 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
    wait_done("div_7_m2"); @(negedge clk);
    issue(OP_DIV, 1'b0, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF);
    wait_done("divu_by0"); @(negedge clk);
    issue(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF);
    wait_done("div_neg_by0"); @(negedge clk);
    issue(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    wait_done("div_minneg"); @(negedge clk);
    issue(OP_DIV, 1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
    wait_done("divu_100_7"); @(negedge clk);

    // 3. MULTU max*max; DIV and MTHI issued while busy are ignored
    issue(OP_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    repeat (4) @(posedge clk); #1;
    op = OP_DIV; sin = 1'b0; in_1 = 32'd100; in_2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    op = OP_MTHI; in_1 = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
    wait_done("multu_busy_ignore");
    @(negedge clk);
    check("after_ignore_idle", busy, 0);

    // 4. Async reset mid-CALC
    op = OP_MULT; sin = 1'b0; in_1 = 32'd3; in_2 = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
    repeat (10) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_hilo", {hi, lo}, 64'h0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy || done) viol++;
    end
    check("arst_no_activity", viol, 0);
    mt("mtlo_after_rst", OP_MTLO, 32'h1234, 64'h0000_0000_0000_1234);

    // 5. Accumulate ops (or their absence)
`ifdef MDU_ACCUM_EN
    mt("mthi_0", OP_MTHI, 32'd0, 64'h0000_0000_0000_1234);
    mt("mtlo_10", OP_MTLO, 32'd10, 64'h0000_0000_0000_000A);
    issue(OP_MADD, 1'b1, 32'hFFFF_FFFE, 32'd3, 64'h0000_0000_0000_0004);
    wait_done("madd"); @(negedge clk);
    issue(OP_MSUB, 1'b1, 32'hFFFF_FFFE, 32'd3, 64'h0000_0000_0000_000A);
    wait_done("msub"); @(negedge clk);
`else
    mt("mthi_55", OP_MTHI, 32'h55, 64'h0000_0055_0000_1234);
    mt("mtlo_aa", OP_MTLO, 32'hAA, 64'h0000_0055_0000_00AA);
    viol = 0;
    sin = 1'b1; in_1 = 32'hFFFF_FFFE; in_2 = 32'd3; start = 1'b1;
    for (int k = 4; k < 8; k++) begin
      op = 3'(k);
      @(posedge clk); #1;
      if (busy) viol++;
    end
    start = 1'b0; op = OP_NONE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy || done) viol++;
    end
    check("reserved_no_activity", viol, 0);
    check("reserved_hilo", {hi, lo}, 64'h0000_0055_0000_00AA);
`endif

    // 6. Back-to-back: DIV issued in the MULT done cycle
    @(negedge clk);
    issue(OP_MULT, 1'b1, 32'd6, 32'd7, 64'h0000_0000_0000_002A);
    wait_done("b2b_mult");
    issue(OP_DIV, 1'b1, 32'd42, 32'd5, 64'h0000_0002_0000_0008);
    measure("b2b_div");

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
